// File: rtl/shift_reg_universal.sv
// Universal shift register: parallel load, logical/arithmetic shifts and rotates,
// with a shift counter that pulses cnt_wrap each time WIDTH shifts have accumulated.
module shift_reg_universal #(
    parameter int                CLK_HZ      = 12_000_000,
    parameter int                WIDTH       = 8,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    localparam int               CW          = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             set,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_l,
    output logic             ser_out_r,
    output logic [CW-1:0]    shift_cnt,
    output logic             cnt_wrap
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROTL = 3'd4,
        MODE_ROTR = 3'd5,
        MODE_ASHR = 3'd6,
        MODE_RSVD = 3'd7
    } mode_e;

    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 64 || CLK_HZ <= 0) begin : g_param_check
        $error("shift_reg_universal: WIDTH must be 2..64 and CLK_HZ positive");
    end

    mode_e            op;
    logic [WIDTH-1:0] shifted;
    logic             is_shift;

    assign op        = mode_e'(mode);
    assign ser_out_l = q[WIDTH-1];
    assign ser_out_r = q[0];

    always_comb begin
        shifted  = q;
        is_shift = 1'b1;
        case (op)
            MODE_SHL:  shifted = {q[WIDTH-2:0], ser_in_r};
            MODE_SHR:  shifted = {ser_in_l, q[WIDTH-1:1]};
            MODE_ROTL: shifted = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROTR: shifted = {q[0], q[WIDTH-1:1]};
            MODE_ASHR: shifted = {q[WIDTH-1], q[WIDTH-1:1]};
            default:   is_shift = 1'b0;
        endcase
    end

    // cnt_wrap defaults low every edge so it can only ever be a single-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q         <= RESET_VALUE;
            shift_cnt <= '0;
            cnt_wrap  <= 1'b0;
        end else begin
            cnt_wrap <= 1'b0;
            if (clr) begin
                q         <= '0;
                shift_cnt <= '0;
            end else if (set) begin
                q         <= '1;
                shift_cnt <= '0;
            end else if (en) begin
                if (op == MODE_LOAD) begin
                    q         <= d;
                    shift_cnt <= '0;
                end else if (is_shift) begin
                    q <= shifted;
                    if (shift_cnt == LAST_CNT) begin
                        shift_cnt <= '0;
                        cnt_wrap  <= 1'b1;
                    end else begin
                        shift_cnt <= shift_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_reg_universal.sv
// Scoreboard bench for shift_reg_universal: an 8-bit (RESET_VALUE=0x3C) and a 5-bit
// instance share stimulus; an arithmetic reference model predicts both.
module tb_shift_reg_universal;

    typedef struct {
        logic [63:0] q;
        int          cnt;
        bit          wrap;
    } model_t;

    typedef struct {
        logic [63:0] q;
        int          cnt;
        bit          wrap;
        string       tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       set = 1'b0;
    logic       en = 1'b0;
    logic [2:0] mode = 3'd0;
    logic [7:0] d = 8'h00;
    logic       ser_in_l = 1'b0;
    logic       ser_in_r = 1'b0;

    logic [7:0] q8;
    logic       sol8, sor8, wrap8;
    logic [2:0] cnt8;
    logic [4:0] q5;
    logic       sol5, sor5, wrap5;
    logic [2:0] cnt5;

    int errors = 0;
    int checks = 0;

    exp_t   exp8[$];
    exp_t   exp5[$];
    model_t m8 = '{q: 64'h3C, cnt: 0, wrap: 0};
    model_t m5 = '{q: 64'h00, cnt: 0, wrap: 0};
    event   chk_now;

    always #5 clk = ~clk;

    shift_reg_universal #(.WIDTH(8), .RESET_VALUE(8'h3C)) dut8 (
        .clk(clk), .rst(rst), .clr(clr), .set(set), .en(en), .mode(mode), .d(d),
        .ser_in_l(ser_in_l), .ser_in_r(ser_in_r), .q(q8), .ser_out_l(sol8),
        .ser_out_r(sor8), .shift_cnt(cnt8), .cnt_wrap(wrap8)
    );

    shift_reg_universal #(.WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .clr(clr), .set(set), .en(en), .mode(mode), .d(d[4:0]),
        .ser_in_l(ser_in_l), .ser_in_r(ser_in_r), .q(q5), .ser_out_l(sol5),
        .ser_out_r(sor5), .shift_cnt(cnt5), .cnt_wrap(wrap5)
    );

    // Reference: shifts as integer arithmetic on a masked value, count as modulo WIDTH.
    function automatic model_t next_state(model_t s, int w, logic [63:0] rv, logic r,
                                          logic c, logic st, logic e, logic [2:0] m,
                                          logic [63:0] dv, logic sl, logic sr);
        model_t      n = s;
        logic [63:0] mask = (64'd1 << w) - 64'd1;
        logic [63:0] msb = 64'd1 << (w - 1);
        bit          shift_op = 1'b1;
        n.wrap = 1'b0;
        if (r) begin
            n.q = rv & mask;
            n.cnt = 0;
        end else if (c) begin
            n.q = 64'd0;
            n.cnt = 0;
        end else if (st) begin
            n.q = mask;
            n.cnt = 0;
        end else if (e) begin
            case (m)
                3'd1: begin n.q = dv & mask; n.cnt = 0; shift_op = 1'b0; end
                3'd2: n.q = ((s.q * 2) + 64'(sr)) & mask;
                3'd3: n.q = (s.q / 2) + (sl ? msb : 64'd0);
                3'd4: n.q = ((s.q * 2) & mask) + ((s.q & msb) != 0 ? 64'd1 : 64'd0);
                3'd5: n.q = (s.q / 2) + (s.q[0] ? msb : 64'd0);
                3'd6: n.q = (s.q / 2) + (s.q & msb);
                default: shift_op = 1'b0;
            endcase
            if (shift_op) begin
                n.cnt = (s.cnt + 1) % w;
                n.wrap = (s.cnt + 1 == w);
            end
        end
        return n;
    endfunction

    function automatic exp_t to_exp(model_t s, string tag);
        exp_t x;
        x.q = s.q;
        x.cnt = s.cnt;
        x.wrap = s.wrap;
        x.tag = tag;
        return x;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic c, input logic st, input logic e,
                                 input logic [2:0] m, input logic [7:0] dv,
                                 input logic sl, input logic sr, input string tag);
        @(negedge clk);
        rst = r; clr = c; set = st; en = e; mode = m; d = dv;
        ser_in_l = sl; ser_in_r = sr;
        m8 = next_state(m8, 8, 64'h3C, r, c, st, e, m, 64'(dv), sl, sr);
        m5 = next_state(m5, 5, 64'h00, r, c, st, e, m, 64'(dv), sl, sr);
        exp8.push_back(to_exp(m8, tag));
        exp5.push_back(to_exp(m5, tag));
    endtask

    // Asynchronous reset raised between edges; checked before the next rising edge.
    task automatic midCycleReset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        m8 = next_state(m8, 8, 64'h3C, 1'b1, 0, 0, 0, 3'd0, 64'd0, 0, 0);
        m5 = next_state(m5, 5, 64'h00, 1'b1, 0, 0, 0, 3'd0, 64'd0, 0, 0);
        exp8.push_back(to_exp(m8, "async_rst"));
        exp5.push_back(to_exp(m5, "async_rst"));
        -> chk_now;
    endtask

    // Monitor: pops and compares whenever outputs have settled after an edge or async event.
    initial begin
        exp_t e8, e5;
        forever begin
            @(posedge clk or chk_now);
            #1;
            while (exp8.size() > 0 && exp5.size() > 0) begin
                e8 = exp8.pop_front();
                e5 = exp5.pop_front();
                checkOutput({e8.tag, " w8 q"},     64'(q8),    e8.q);
                checkOutput({e8.tag, " w8 cnt"},   64'(cnt8),  64'(e8.cnt));
                checkOutput({e8.tag, " w8 wrap"},  64'(wrap8), 64'(e8.wrap));
                checkOutput({e8.tag, " w8 sol"},   64'(sol8),  (e8.q >> 7) & 64'd1);
                checkOutput({e8.tag, " w8 sor"},   64'(sor8),  e8.q & 64'd1);
                checkOutput({e5.tag, " w5 q"},     64'(q5),    e5.q);
                checkOutput({e5.tag, " w5 cnt"},   64'(cnt5),  64'(e5.cnt));
                checkOutput({e5.tag, " w5 wrap"},  64'(wrap5), 64'(e5.wrap));
                checkOutput({e5.tag, " w5 sol"},   64'(sol5),  (e5.q >> 4) & 64'd1);
                checkOutput({e5.tag, " w5 sor"},   64'(sor5),  e5.q & 64'd1);
            end
        end
    end

    initial begin
        // Held in reset through edges with activity on the inputs.
        applyStimulus(1, 0, 0, 1, 3'd2, 8'hFF, 1, 1, "rst_hold");
        applyStimulus(1, 0, 0, 1, 3'd1, 8'h77, 1, 1, "rst_hold");

        applyStimulus(0, 0, 0, 1, 3'd1, 8'hA5, 0, 0, "load_a5");
        applyStimulus(0, 0, 0, 1, 3'd2, 8'h00, 0, 1, "shl");
        applyStimulus(0, 0, 0, 1, 3'd1, 8'hA5, 0, 0, "load_a5");
        applyStimulus(0, 0, 0, 1, 3'd3, 8'h00, 0, 0, "shr");
        applyStimulus(0, 0, 0, 1, 3'd1, 8'hA5, 0, 0, "load_a5");
        applyStimulus(0, 0, 0, 1, 3'd6, 8'h00, 1, 1, "ashr");
        applyStimulus(0, 0, 0, 1, 3'd1, 8'h81, 0, 0, "load_81");
        applyStimulus(0, 0, 0, 1, 3'd4, 8'h00, 0, 0, "rotl");
        applyStimulus(0, 0, 0, 1, 3'd1, 8'h81, 0, 0, "load_81");
        applyStimulus(0, 0, 0, 1, 3'd5, 8'h00, 0, 0, "rotr");

        // Eight rotates with an en=0 gap: the pulse lands after the 8th shift edge.
        applyStimulus(0, 0, 0, 1, 3'd1, 8'h01, 0, 0, "load_01");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 3'd4, 8'h00, 0, 0, "rotl_seq");
        applyStimulus(0, 0, 0, 0, 3'd4, 8'h00, 0, 0, "en_gap");
        applyStimulus(0, 0, 0, 0, 3'd2, 8'h00, 1, 1, "en_gap");
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 3'd4, 8'h00, 0, 0, "rotl_seq");
        applyStimulus(0, 0, 0, 1, 3'd0, 8'h00, 0, 0, "hold");
        applyStimulus(0, 0, 0, 1, 3'd7, 8'h00, 0, 0, "rsvd");

        applyStimulus(0, 1, 1, 1, 3'd1, 8'hFF, 0, 0, "clr_set");
        applyStimulus(0, 0, 1, 0, 3'd0, 8'h00, 0, 0, "set_noen");

        // Clear coincident with what would be the wrapping edge of the 5-bit instance.
        applyStimulus(0, 0, 0, 1, 3'd1, 8'h00, 0, 0, "load_00");
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 3'd2, 8'h00, 0, 1, "shl_seq");
        applyStimulus(0, 1, 0, 1, 3'd2, 8'h00, 0, 1, "clr_on_wrap");
        applyStimulus(0, 0, 0, 1, 3'd0, 8'h00, 0, 0, "no_pulse");

        // Five shifts, async reset mid-cycle, then held through two SHL edges.
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 3'd2, 8'h00, 1, 1, "shl5");
        midCycleReset();
        applyStimulus(1, 0, 0, 1, 3'd2, 8'h00, 1, 1, "rst_shl");
        applyStimulus(1, 0, 0, 1, 3'd2, 8'h00, 1, 1, "rst_shl");
        applyStimulus(0, 0, 0, 1, 3'd2, 8'h00, 1, 1, "resume");

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 3) != 0),
                          3'($urandom_range(0, 7)),
                          8'($urandom),
                          1'($urandom), 1'($urandom), "rand");
        end

        @(posedge clk);
        #3;
        checkOutput("scoreboard_drain", 64'(exp8.size() + exp5.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
